uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 4 to 65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port data_in, input, 1 bit: serial line, idle high, 8N1 framing, LSB first.
REQ-005 The block SHALL have port data_out, output, 8 bits: last correctly framed received byte.
REQ-006 The block SHALL have port rx_ready, output, 1 bit: data_out holds an unacknowledged byte.
REQ-007 The block SHALL have port rx_ack, input, 1 bit: consumer acknowledge; clears rx_ready.
REQ-008 The block SHALL have port rx_busy, output, 1 bit: a frame is being received.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag; a byte was overwritten before being acknowledged.

Function
REQ-011 data_in SHALL pass through a 2-flop synchronizer; all sampling below uses the synchronized value (rxs).
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 A bit counter SHALL count 0..CLKS_PER_BIT-1, be sized to hold CLKS_PER_BIT-1, and reset to 0 on every state entry and on every sample.
REQ-014 IDLE: when rxs=0, the FSM SHALL go to START with the counter at 0.
REQ-015 START: at count CLKS_PER_BIT/2-1 (integer division), the FSM SHALL sample rxs; rxs=1 is a glitch and returns to IDLE with no flags; rxs=0 goes to DATA.
REQ-016 DATA: every CLKS_PER_BIT cycles, the FSM SHALL sample rxs into shift bit index 0..7, LSB first; after index 7 it SHALL go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, the FSM SHALL sample rxs; rxs=1 loads data_out and sets rx_ready on the next edge, then goes to IDLE.
REQ-018 STOP with rxs=0: frame_err SHALL pulse high for exactly 1 cycle, data_out and rx_ready SHALL be unchanged, and the FSM SHALL go to WAIT_IDLE.
REQ-019 WAIT_IDLE: the FSM SHALL stay until rxs=1, then go to IDLE; no start bit is accepted while in WAIT_IDLE.
REQ-020 rx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE and WAIT_IDLE.
REQ-021 Latency SHALL be 1 clk from the stop-bit sample edge to rx_ready=1 with data_out valid.
REQ-022 rx_ack=1 while rx_ready=1 SHALL clear rx_ready and overrun on the next edge; rx_ack while rx_ready=0 SHALL have no effect.
REQ-023 Good-byte completion while rx_ready=1 and rx_ack=0 SHALL overwrite data_out, keep rx_ready=1, and set overrun.
REQ-024 Good-byte completion in the same cycle as rx_ack=1 SHALL load the new byte, keep rx_ready=1, and leave overrun=0.
REQ-025 rx_ack SHALL NOT affect reception in progress.
REQ-026 A back-to-back frame whose start bit immediately follows the stop bit SHALL be received without loss.

Reset
REQ-027 rst=1 SHALL immediately force: FSM to IDLE, counter and bit index to 0, shift register and data_out to 0x00, rx_ready=0, rx_busy=0, frame_err=0, overrun=0, synchronizer flops to 1.
REQ-028 rst asserted mid-frame SHALL discard the partial byte; after release, reception resumes on the next falling edge of rxs.

Verification (CLKS_PER_BIT=4, clk period 100 ns)
REQ-029 Bench SHALL cover: frame 0xCF (bits 1,1,1,1,0,0,1,1 after start) -> data_out=0xCF, rx_ready=1, frame_err=0, overrun=0.
REQ-030 Bench SHALL cover: 0x55 then 0xAA back-to-back, rx_ack after each -> both bytes read in order, overrun=0.
REQ-031 Bench SHALL cover: 0x12 then 0x34 with no rx_ack -> data_out=0x34, rx_ready=1, overrun=1; rx_ack -> rx_ready=0, overrun=0.
REQ-032 Bench SHALL cover: 0x3C with stop bit low -> frame_err pulse of 1 cycle, data_out unchanged; a new start while the line is low is ignored until the line goes high.
REQ-033 Bench SHALL cover: a 1-cycle low glitch on idle line -> rx_busy returns to 0 by the half-bit point, no rx_ready, no frame_err.
REQ-034 Bench SHALL cover: rst pulse during DATA bit 3 -> all outputs 0 at once; the next clean 0xA5 frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first. The serial line is synchronized, the start
// bit is confirmed at its half-bit point, and every following bit is sampled
// one full bit period later, i.e. near the middle of each bit. Good bytes are
// handed over through a ready/ack pair with a sticky overrun flag. Bad stop
// bits raise a one-cycle frame error, then the receiver waits for an idle
// line before it accepts another start bit.
module uart_receiver #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_in,
   input  logic       rx_ack,
   output logic [7:0] data_out,
   output logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          rxs;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          busy_q, busy_d;

   assign rxs = sync2_q;

   // Two-flop synchronizer; resets to the idle-high line level so a reset
   // release never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= data_in;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic: bit timing, shifting, hand-over and error flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = ready_q;
      ferr_d  = 1'b0;
      ovr_d   = ovr_q;

      // Acknowledge only matters while a byte is pending.
      if (rx_ack && ready_q) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         ready_d = ready_q;
         ovr_d   = ovr_q;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = {CW{1'b0}};
            idx_d = 3'd0;
            if (!rxs) begin
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = {CW{1'b0}};
               if (rxs) begin
                  state_d = S_IDLE;   // glitch, not a real start bit
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d          = {CW{1'b0}};
               shift_d[idx_q] = rxs;
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = {CW{1'b0}};
               if (rxs) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  // Overwriting an unacknowledged byte is an overrun; a
                  // same-cycle ack means the old byte was consumed in time.
                  ovr_d   = (ready_q && !rx_ack) ? 1'b1 :
                            ((ready_q && rx_ack) ? 1'b0 : ovr_q);
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_IDLE: begin
            cnt_d = {CW{1'b0}};
            if (rxs) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
            idx_d   = 3'd0;
         end
      endcase

      busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out  = data_q;
   assign rx_ready  = ready_q;
   assign rx_busy   = busy_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with 4 clocks per bit and a 100 ns clock.
module tb_uart_receiver;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       data_in;
   logic       rx_ack;
   logic [7:0] data_out;
   logic       rx_ready;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;
   int fe_cnt;
   int busy_cnt;
   int rdy_cnt;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .rx_ack    (rx_ack),
      .data_out  (data_out),
      .rx_ready  (rx_ready),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // 100 ns clock.
   always #50 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_bit);
   endtask

   task automatic ack;
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
   endtask

   // Absolute time limit so the run always ends.
   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      data_in = 1'b1;
      rx_ack  = 1'b0;
      tick(3);
      chk8("reset_data_out", data_out, 8'h00);
      chk1("reset_rx_ready", rx_ready, 1'b0);
      chk1("reset_rx_busy", rx_busy, 1'b0);
      chk1("reset_frame_err", frame_err, 1'b0);
      chk1("reset_overrun", overrun, 1'b0);
      rst = 1'b0;
      tick(2);

      // Single good frame 0xCF.
      send_frame(8'hCF, 1'b1);
      tick(2);
      chk8("cf_data_out", data_out, 8'hCF);
      chk1("cf_rx_ready", rx_ready, 1'b1);
      chk1("cf_frame_err", frame_err, 1'b0);
      chk1("cf_overrun", overrun, 1'b0);
      chk1("cf_rx_busy", rx_busy, 1'b0);
      ack;
      chk1("cf_ack_clears_ready", rx_ready, 1'b0);
      ack;
      chk1("idle_ack_ready", rx_ready, 1'b0);
      chk1("idle_ack_overrun", overrun, 1'b0);
      chk8("idle_ack_data_out", data_out, 8'hCF);

      // Back-to-back 0x55 / 0xAA, first byte acknowledged mid-reception.
      send_frame(8'h55, 1'b1);
      fork
         send_frame(8'hAA, 1'b1);
         begin
            tick(2);
            chk8("b2b_first_data", data_out, 8'h55);
            chk1("b2b_first_ready", rx_ready, 1'b1);
            ack;
            chk1("b2b_first_acked", rx_ready, 1'b0);
            chk1("b2b_busy_during_second", rx_busy, 1'b1);
         end
      join
      tick(2);
      chk8("b2b_second_data", data_out, 8'hAA);
      chk1("b2b_second_ready", rx_ready, 1'b1);
      chk1("b2b_overrun", overrun, 1'b0);
      ack;
      chk1("b2b_second_acked", rx_ready, 1'b0);

      // Overrun: 0x12 then 0x34 without acknowledge.
      send_frame(8'h12, 1'b1);
      tick(3);
      send_frame(8'h34, 1'b1);
      tick(2);
      chk8("ovr_data_out", data_out, 8'h34);
      chk1("ovr_rx_ready", rx_ready, 1'b1);
      chk1("ovr_overrun", overrun, 1'b1);
      ack;
      chk1("ovr_ack_ready", rx_ready, 1'b0);
      chk1("ovr_ack_overrun", overrun, 1'b0);

      // Framing error on 0x3C, line then held low.
      send_frame(8'h3C, 1'b0);
      fe_cnt   = 0;
      busy_cnt = 0;
      rdy_cnt  = 0;
      tick(1);
      chk1("ferr_pulse_high", frame_err, 1'b1);
      for (int i = 0; i < 20; i++) begin
         fe_cnt   += int'(frame_err);
         busy_cnt += int'(rx_busy);
         rdy_cnt  += int'(rx_ready);
         tick(1);
      end
      chkn("ferr_pulse_width", fe_cnt, 1);
      chkn("ferr_low_line_no_busy", busy_cnt, 0);
      chkn("ferr_no_ready", rdy_cnt, 0);
      chk8("ferr_data_unchanged", data_out, 8'h34);
      data_in = 1'b1;
      tick(4);
      send_frame(8'h5A, 1'b1);
      tick(2);
      chk8("after_ferr_data", data_out, 8'h5A);
      chk1("after_ferr_ready", rx_ready, 1'b1);
      chk1("after_ferr_frame_err", frame_err, 1'b0);
      ack;
      chk1("after_ferr_acked", rx_ready, 1'b0);

      // One-cycle glitch on an idle line.
      data_in = 1'b0;
      tick(1);
      data_in = 1'b1;
      tick(3);
      chk1("glitch_busy_seen", rx_busy, 1'b1);
      tick(2);
      chk1("glitch_busy_cleared", rx_busy, 1'b0);
      fe_cnt  = 0;
      rdy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         fe_cnt  += int'(frame_err);
         rdy_cnt += int'(rx_ready);
         tick(1);
      end
      chkn("glitch_no_frame_err", fe_cnt, 0);
      chkn("glitch_no_ready", rdy_cnt, 0);

      // Reset during data bit 3 with a pending byte, then a clean 0xA5.
      send_frame(8'h77, 1'b1);
      tick(2);
      chk1("pre_rst_ready", rx_ready, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      data_in = 1'b0;
      tick(2);
      chk1("pre_rst_busy", rx_busy, 1'b1);
      rst = 1'b1;
      #10;
      chk8("rst_data_out", data_out, 8'h00);
      chk1("rst_rx_ready", rx_ready, 1'b0);
      chk1("rst_rx_busy", rx_busy, 1'b0);
      chk1("rst_frame_err", frame_err, 1'b0);
      chk1("rst_overrun", overrun, 1'b0);
      tick(2);
      data_in = 1'b1;
      rst     = 1'b0;
      tick(4);
      chk1("post_rst_idle", rx_busy, 1'b0);
      send_frame(8'hA5, 1'b1);
      tick(2);
      chk8("post_rst_data", data_out, 8'hA5);
      chk1("post_rst_ready", rx_ready, 1'b1);
      chk1("post_rst_frame_err", frame_err, 1'b0);
      chk1("post_rst_overrun", overrun, 1'b0);
      ack;
      chk1("post_rst_acked", rx_ready, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
